// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
package cpu_run_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned CYCLE_W_DEF = 32;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 3'd0,
        RST_HOLD   = 3'd1,
        RUN        = 3'd2,
        STEP_WAIT  = 3'd3,
        STEP_PULSE = 3'd4,
        DONE       = 3'd5
    } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl_sat_cycle_counter.sv
// Saturating executed-cycle counter with clear, increment enable and a
// combinational flag for "one cycle before limit".
module sat_cycle_counter
    import cpu_run_pkg::*;
#(
    parameter int unsigned CYCLE_W = CYCLE_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               inc_i,
    input  logic [CYCLE_W-1:0] limit_i,
    output logic [CYCLE_W-1:0] count_o,
    output logic               at_limit_c_o
);

    logic [CYCLE_W-1:0] count_q;
    logic [CYCLE_W-1:0] count_d;

    // Clear wins over increment; increment stops at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CYCLE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign at_limit_c_o = (count_q == (limit_i - CYCLE_W'(1)));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined CPU: sequences CPU reset, gates execution
// via clock enable, supports free-run / single-step and stops on halt or limit.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned CYCLE_W    = CYCLE_W_DEF,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               step_mode_i,
    input  logic               step_req_i,
    input  logic               halt_in_i,
    output logic               cpu_reset_o,
    output logic               cpu_clk_en_o,
    output logic [CYCLE_W-1:0] cycle_count_o,
    output logic               running_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int unsigned HOLD_W = $clog2(RST_CYCLES) + 1;

    run_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              clk_en_q, clk_en_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              cnt_clr, cnt_inc;
    logic              at_limit;
    logic              lim_hit;

    sat_cycle_counter #(
        .CYCLE_W (CYCLE_W)
    ) u_cnt (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (cnt_clr),
        .inc_i        (cnt_inc),
        .limit_i      (CYCLE_W'(MAX_CYCLES)),
        .count_o      (cycle_count_o),
        .at_limit_c_o (at_limit)
    );

    assign lim_hit = (MAX_CYCLES != 0) && at_limit;

    // Next state; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        timeout_d = timeout_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d   = RST_HOLD;
                    hold_d    = '0;
                    cnt_clr   = 1'b1;
                    timeout_d = 1'b0;
                end
            end
            RST_HOLD: begin
                hold_d = HOLD_W'(hold_q + HOLD_W'(1));
                if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
                    state_d = step_mode_i ? STEP_WAIT : RUN;
                end
            end
            RUN, STEP_PULSE: begin
                cnt_inc = 1'b1;
                if (halt_in_i) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                end else if (lim_hit) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else if ((state_q == STEP_PULSE) || step_mode_i) begin
                    state_d = STEP_WAIT;
                end
            end
            STEP_WAIT: begin
                if (halt_in_i) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                end else if (!step_mode_i) begin
                    state_d = RUN;
                end else if (step_req_i) begin
                    state_d = STEP_PULSE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_reset_d = (state_d == IDLE) || (state_d == RST_HOLD);
        clk_en_d    = (state_d == RST_HOLD) || (state_d == RUN) || (state_d == STEP_PULSE);
        running_d   = (state_d == RUN) || (state_d == STEP_WAIT) || (state_d == STEP_PULSE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            cpu_reset_q <= 1'b1;
            clk_en_q    <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cpu_reset_q <= cpu_reset_d;
            clk_en_q    <= clk_en_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cpu_reset_o  = cpu_reset_q;
    assign cpu_clk_en_o = clk_en_q;
    assign running_o    = running_q;
    assign done_o       = done_q;
    assign timeout_o    = timeout_q;
    assign state_o      = state_q;

endmodule
